// File: rtl/buzzer_sched_if.sv
// buzzer_sched_if: requester/tone-generator bundle for buzzer_sched.
//   req       [2:0]  request per requester (2 = alarm, 1 = key-click, 0 = melody)
//   note      [14:0] packed 5-bit note codes, requester i at [5i+4:5i]
//   beats     [11:0] packed 4-bit durations, requester i at [4i+3:4i]
//   ack       [2:0]  one-cycle pulse: request accepted, note/beats captured
//   grant     [2:0]  one-hot, currently sounding requester
//   done      [2:0]  one-cycle pulse: note completed normally
//   abort     [2:0]  one-cycle pulse: note preempted
//   tone_code [4:0]  code to the tone generator, 0 = silence
//   busy             scheduler is playing a note or its gap
// master = requester side, slave = scheduler side.
interface buzzer_sched_if;
  logic [2:0]  req;
  logic [14:0] note;
  logic [11:0] beats;
  logic [2:0]  ack;
  logic [2:0]  grant;
  logic [2:0]  done;
  logic [2:0]  abort;
  logic [4:0]  tone_code;
  logic        busy;

  modport master (output req, note, beats,
                  input  ack, grant, done, abort, tone_code, busy);
  modport slave  (input  req, note, beats,
                  output ack, grant, done, abort, tone_code, busy);
endinterface

// File: rtl/buzzer_sched.sv
// buzzer_sched: fixed-priority scheduler sharing one buzzer tone generator
// among three requesters (melody, key-click, alarm). Grants one requester,
// plays its note for max(beats,1) beats of BEAT_DIV cycles, then inserts a
// silent gap of GAP_CYC cycles. All outputs are registered.
//   i_clk  system clock, rising edge
//   i_rst  synchronous active-high reset
//   bus    buzzer_sched_if.slave (req/note/beats in; ack/grant/done/abort/
//          tone_code/busy out)
// Optional feature: define BUZZER_PREEMPT_EN to let a higher-priority request
// preempt a playing note (abort pulse, immediate switch, no gap). Without it
// abort stays 0 and the scheduler is strictly non-preemptive.
module buzzer_sched #(
  parameter int BEAT_DIV = 12500000,
  parameter int GAP_CYC  = 1000000
) (
  input  logic           i_clk,
  input  logic           i_rst,
  buzzer_sched_if.slave  bus
);
  localparam int CW = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [CW-1:0] CYC_LD = CW'(BEAT_DIV - 1);
  localparam logic [GW-1:0] GAP_LD = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [4:0] NOTE_MAX = 5'd21;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_cur, w_cur_nxt, w_hi;
  logic [3:0]      r_beats, w_beats_nxt;
  logic [CW-1:0]   r_cyc, w_cyc_nxt;
  logic [GW-1:0]   r_gap, w_gap_nxt;
  logic [2:0]      r_ack, w_ack_nxt;
  logic [2:0]      r_grant, w_grant_nxt;
  logic [2:0]      r_done, w_done_nxt;
  logic [2:0]      r_abort, w_abort_nxt;
  logic [4:0]      r_tone, w_tone_nxt;
  logic            r_busy, w_busy_nxt;
  logic            w_load;
  logic [2:0][4:0] w_notes;
  logic [2:0][3:0] w_beats;
  logic [4:0]      w_note_sel;
  logic [3:0]      w_beats_sel;

  assign w_notes     = bus.note;
  assign w_beats     = bus.beats;
  assign w_note_sel  = w_notes[w_hi];
  assign w_beats_sel = w_beats[w_hi];

  // Highest set request index; only meaningful when req != 0.
  always_comb begin
    w_hi = 2'd0;
    if (bus.req[2])      w_hi = 2'd2;
    else if (bus.req[1]) w_hi = 2'd1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_beats_nxt = r_beats;
    w_cyc_nxt   = r_cyc;
    w_gap_nxt   = r_gap;
    w_ack_nxt   = '0;
    w_done_nxt  = '0;
    w_abort_nxt = '0;
    w_grant_nxt = r_grant;
    w_tone_nxt  = r_tone;
    w_load      = 1'b0;

    case (r_state)
      IDLE: if (bus.req != 3'b000) w_load = 1'b1;
      PLAY: begin
`ifdef BUZZER_PREEMPT_EN
        // Preemption wins over a same-cycle last-beat completion.
        if (bus.req != 3'b000 && w_hi > r_cur) begin
          w_load             = 1'b1;
          w_abort_nxt[r_cur] = 1'b1;
        end else begin
`else
        begin
`endif
          if (r_cyc == '0) begin
            if (r_beats <= 4'd1) begin
              w_done_nxt[r_cur] = 1'b1;
              w_grant_nxt       = '0;
              w_tone_nxt        = '0;
              w_gap_nxt         = GAP_LD;
              w_state_nxt       = (GAP_CYC == 0) ? IDLE : GAP;
            end else begin
              w_beats_nxt = r_beats - 4'd1;
              w_cyc_nxt   = CYC_LD;
            end
          end else begin
            w_cyc_nxt = r_cyc - 1'b1;
          end
        end
      end
      GAP: begin
        if (r_gap == '0) w_state_nxt = IDLE;
        else             w_gap_nxt   = r_gap - 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase

    // Accept the highest-priority request: capture note/beats, restart timing.
    if (w_load) begin
      w_state_nxt      = PLAY;
      w_cur_nxt        = w_hi;
      w_ack_nxt[w_hi]  = 1'b1;
      w_grant_nxt      = 3'b001 << w_hi;
      w_tone_nxt       = (w_note_sel > NOTE_MAX) ? 5'd0 : w_note_sel;
      w_beats_nxt      = (w_beats_sel == 4'd0) ? 4'd1 : w_beats_sel;
      w_cyc_nxt        = CYC_LD;
    end

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cur   <= '0;
      r_beats <= '0;
      r_cyc   <= '0;
      r_gap   <= '0;
      r_ack   <= '0;
      r_grant <= '0;
      r_done  <= '0;
      r_abort <= '0;
      r_tone  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      r_beats <= w_beats_nxt;
      r_cyc   <= w_cyc_nxt;
      r_gap   <= w_gap_nxt;
      r_ack   <= w_ack_nxt;
      r_grant <= w_grant_nxt;
      r_done  <= w_done_nxt;
      r_abort <= w_abort_nxt;
      r_tone  <= w_tone_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign bus.ack       = r_ack;
  assign bus.grant     = r_grant;
  assign bus.done      = r_done;
  assign bus.abort     = r_abort;
  assign bus.tone_code = r_tone;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_buzzer_sched.sv
// tb_buzzer_sched: directed scenarios plus randomized requesters, checked
// every cycle against a duration/gap countdown model of the scheduler.
module tb_buzzer_sched;
  localparam int BD = 4;
  localparam int GC = 2;
`ifdef BUZZER_PREEMPT_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  buzzer_sched_if bus();

  buzzer_sched #(.BEAT_DIV(BD), .GAP_CYC(GC)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference: a note is a single countdown of max(beats,1)*BD tone cycles
  // followed by GC silent cycles; idle when both have run out.
  initial begin : model
    int m_play, m_gap, m_cur, hi, n, b;
    logic       s_rst, load;
    logic [2:0] s_req, e_ack, e_grant, e_done, e_abort;
    logic [14:0] s_note;
    logic [11:0] s_beats;
    logic [4:0] e_tone;
    logic       e_busy;
    m_play = 0; m_gap = 0; m_cur = 0;
    e_grant = '0; e_tone = '0;
    forever begin
      @(posedge clk);
      s_rst = rst; s_req = bus.req; s_note = bus.note; s_beats = bus.beats;
      e_ack = '0; e_done = '0; e_abort = '0; load = 1'b0;
      hi = s_req[2] ? 2 : (s_req[1] ? 1 : 0);
      if (s_rst) begin
        m_play = 0; m_gap = 0; m_cur = 0; e_grant = '0; e_tone = '0;
      end else begin
        if (m_play > 0) begin
          if (PRE && s_req != 0 && hi > m_cur) begin
            load = 1'b1;
            e_abort[m_cur] = 1'b1;
          end else begin
            m_play--;
            if (m_play == 0) begin
              e_done[m_cur] = 1'b1;
              e_grant = '0;
              e_tone = '0;
              m_gap = GC;
            end
          end
        end else if (m_gap > 0) begin
          m_gap--;
        end else if (s_req != 0) begin
          load = 1'b1;
        end
        if (load) begin
          m_cur = hi;
          e_ack[hi] = 1'b1;
          e_grant = 3'b001 << hi;
          n = int'(s_note[hi*5 +: 5]);
          e_tone = (n > 21) ? 5'd0 : 5'(n);
          b = int'(s_beats[hi*4 +: 4]);
          m_play = ((b == 0) ? 1 : b) * BD;
          m_gap = 0;
        end
      end
      e_busy = (m_play > 0) || (m_gap > 0);
      @(negedge clk);
      chk("ack",   bus.ack,       e_ack);
      chk("grant", bus.grant,     e_grant);
      chk("done",  bus.done,      e_done);
      chk("abort", bus.abort,     e_abort);
      chk("tone",  bus.tone_code, e_tone);
      chk("busy",  bus.busy,      e_busy);
    end
  end

  task automatic put(input int i, input logic [4:0] n, input logic [3:0] b);
    bus.note[i*5 +: 5]  = n;
    bus.beats[i*4 +: 4] = b;
    bus.req[i]          = 1'b1;
  endtask

  // kind: 0 ack[idx], 1 done[idx], 2 abort[idx], 3 busy low, 4 any ack
  task automatic wait_sig(input int kind, input int idx, input int lim, output int at);
    logic hit;
    at = -1;
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      case (kind)
        0:       hit = bus.ack[idx];
        1:       hit = bus.done[idx];
        2:       hit = bus.abort[idx];
        3:       hit = !bus.busy;
        default: hit = (bus.ack != 3'b000);
      endcase
      if (hit) begin
        at = cyc;
        return;
      end
    end
    n_vec++;
    n_err++;
    $display("FAIL wait kind %0d idx %0d: no event within %0d cycles", kind, idx, lim);
  endtask

  initial begin : stim
    int a, a1, d, e, c0;
    bus.req = '0; bus.note = '0; bus.beats = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic note: 9 for 2 beats.
    c0 = cyc;
    put(0, 5'd9, 4'd2);
    wait_sig(0, 0, 20, a);
    bus.req[0] = 1'b0;
    chk("basic_ack_lat", a - c0, 1);
    chk("basic_tone", bus.tone_code, 9);
    wait_sig(1, 0, 40, d);
    chk("basic_done_lat", d - a, 8);
    chk("basic_gap_tone", bus.tone_code, 0);
    wait_sig(3, 0, 40, e);
    chk("basic_busy_fall", e - d, 2);

    // Priority: simultaneous req 011, one beat each.
    put(1, 5'd5, 4'd1);
    put(0, 5'd7, 4'd1);
    wait_sig(4, 0, 20, a1);
    chk("prio_first", bus.ack, 3'b010);
    bus.req[1] = 1'b0;
    wait_sig(0, 0, 40, a);
    bus.req[0] = 1'b0;
    chk("prio_spacing", a - a1, 7);
    chk("prio_tone", bus.tone_code, 7);
    wait_sig(3, 0, 40, e);

    // Boundary: beats 0 plays one beat, code 25 is a rest.
    put(2, 5'd25, 4'd0);
    wait_sig(0, 2, 20, a);
    bus.req[2] = 1'b0;
    chk("rest_tone", bus.tone_code, 0);
    chk("rest_grant", bus.grant, 3'b100);
    wait_sig(1, 2, 40, d);
    chk("rest_len", d - a, 4);
    wait_sig(3, 0, 40, e);

    // Preemption attempt: alarm rises 3 cycles into a 3-beat melody note.
    put(0, 5'd3, 4'd3);
    wait_sig(0, 0, 20, a);
    bus.req[0] = 1'b0;
    repeat (3) @(negedge clk);
    put(2, 5'd12, 4'd1);
    wait_sig(0, 2, 60, a1);
    bus.req[2] = 1'b0;
`ifdef BUZZER_PREEMPT_EN
    chk("pre_ack_lat", a1 - a, 4);
    chk("pre_abort", bus.abort, 3'b001);
`else
    chk("nopre_ack_lat", a1 - a, 15);
    chk("nopre_abort", bus.abort, 3'b000);
`endif
    chk("pre_tone", bus.tone_code, 12);
    wait_sig(3, 0, 60, e);

    // Reset mid-note with req[1] held.
    put(1, 5'd14, 4'd4);
    wait_sig(0, 1, 20, a);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_grant", bus.grant, 0);
    chk("rst_tone", bus.tone_code, 0);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_reack", bus.ack, 3'b010);
    bus.req[1] = 1'b0;
    wait_sig(3, 0, 80, e);

    // Randomized requesters; occasionally hold req past ack (repeat note).
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < 3; i++) begin
        if (bus.req[i] && bus.ack[i]) begin
          if ($urandom_range(0, 3) != 0) bus.req[i] = 1'b0;
          bus.note[i*5 +: 5]  = 5'($urandom_range(0, 31));
          bus.beats[i*4 +: 4] = 4'($urandom_range(0, 3));
        end else if (!bus.req[i] && $urandom_range(0, 9) == 0) begin
          put(i, 5'($urandom_range(0, 31)),
              ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3)));
        end
      end
    end
    @(negedge clk);
    rst = 1'b0;
    bus.req = '0;
    wait_sig(3, 0, 200, e);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
